// File: rtl/vend_pkg.sv
// Shared definitions for the N-product vending controller: FSM state encoding,
// coin codes and values, and the 7-segment digit table.
package vend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEL    = 2'd1,
    ST_VEND   = 2'd2,
    ST_CHANGE = 2'd3
  } state_t;

  localparam logic [2:0] COIN_NONE = 3'b000;
  localparam logic [2:0] COIN_1    = 3'b001;
  localparam logic [2:0] COIN_2    = 3'b010;
  localparam logic [2:0] COIN_5    = 3'b100;

  localparam logic [2:0] VAL_1 = 3'd1;
  localparam logic [2:0] VAL_2 = 3'd2;
  localparam logic [2:0] VAL_5 = 3'd5;

  // Value of a coin code; invalid codes are worth nothing and are never events.
  function automatic logic [2:0] coin_value(input logic [2:0] code);
    case (code)
      COIN_1:  return VAL_1;
      COIN_2:  return VAL_2;
      COIN_5:  return VAL_5;
      default: return 3'd0;
    endcase
  endfunction

  // Decimal digit to segments gfedcba, active-high; non-decimal codes blank.
  function automatic logic [6:0] seg7_of(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

endpackage

// File: rtl/vend_seg7.sv
// One 7-segment digit decoder for the credit display.
module vend_seg7
  import vend_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [6:0] o_seg
);

  assign o_seg = seg7_of(i_digit);

endmodule

// File: rtl/vending_ctrl_n.sv
// N-product vending controller: coin crediting, product selection, timed
// dispense, greedy coin-by-coin change and a two-digit credit display.
module vending_ctrl_n
  import vend_pkg::*;
#(
  parameter int                         N_PROD      = 3,
  parameter int                         CREDIT_W    = 7,
  parameter int                         MAX_CREDIT  = 99,
  parameter logic [N_PROD*CREDIT_W-1:0] PRICES      = {7'd4, 7'd3, 7'd2},
  parameter int                         DISP_CYC    = 5,
  parameter int                         TIMEOUT_CYC = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_PROD-1:0] BTN,
  input  logic              cancel,
  input  logic [2:0]        Money_in,
  output logic [N_PROD-1:0] product,
  output logic              delivered,
  output logic [N_PROD-1:0] LED,
  output logic [2:0]        change_coin,
  output logic              coin_reject,
  output logic              busy,
  output logic [6:0]        digit0,
  output logic [6:0]        digit1
);

  localparam int SEL_W   = (N_PROD > 1) ? $clog2(N_PROD) : 1;
  localparam int TMR_MAX = (TIMEOUT_CYC > DISP_CYC) ? TIMEOUT_CYC : DISP_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] TMR_TO   = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [TMR_W-1:0] TMR_DISP = TMR_W'(DISP_CYC - 1);

  state_t              r_state;
  logic [N_PROD-1:0]   r_btn_s, r_btn_d;
  logic                r_cancel_s, r_cancel_d;
  logic [2:0]          r_money_s, r_money_d;
  logic [CREDIT_W-1:0] r_credit, r_rem;
  logic [SEL_W-1:0]    r_sel;
  logic [TMR_W-1:0]    r_timer;

  logic                w_btn_ev, w_cancel_ev, w_coin_ev, w_fits, w_accept, w_reach;
  logic [2:0]          w_coin_val, w_chg_code, w_chg_val;
  logic [CREDIT_W:0]   w_sum;
  logic [CREDIT_W-1:0] w_credit_nxt, w_price;
  logic [SEL_W-1:0]    w_btn_idx;
  logic [3:0]          w_tens, w_units;

  // Sample the board inputs once and keep the previous sample for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_btn_s    <= '0;
      r_btn_d    <= '0;
      r_cancel_s <= 1'b0;
      r_cancel_d <= 1'b0;
      r_money_s  <= COIN_NONE;
      r_money_d  <= COIN_NONE;
    end else begin
      r_btn_s    <= BTN;
      r_btn_d    <= r_btn_s;
      r_cancel_s <= cancel;
      r_cancel_d <= r_cancel_s;
      r_money_s  <= Money_in;
      r_money_d  <= r_money_s;
    end
  end

  // An event is a move away from all-zero; a held level counts only once.
  assign w_btn_ev    = (r_btn_d == '0) && (r_btn_s != '0);
  assign w_cancel_ev = r_cancel_s & ~r_cancel_d;
  assign w_coin_val  = coin_value(r_money_s);
  assign w_coin_ev   = (r_money_d == COIN_NONE) && (w_coin_val != 3'd0);

  // Credit add carries one extra bit so an overflowing coin is seen, never wrapped.
  assign w_sum        = {1'b0, r_credit} + (CREDIT_W+1)'(w_coin_val);
  assign w_fits       = (w_sum <= (CREDIT_W+1)'(MAX_CREDIT));
  assign w_accept     = w_coin_ev && w_fits;
  assign w_credit_nxt = w_accept ? w_sum[CREDIT_W-1:0] : r_credit;
  assign w_reach      = w_accept && (w_sum >= {1'b0, w_price});

  // Lowest-index pressed button wins when several rise together.
  always_comb begin
    w_btn_idx = '0;
    for (int i = N_PROD - 1; i >= 0; i--) begin
      if (r_btn_s[i]) w_btn_idx = SEL_W'(i);
    end
  end

  // Price lookup for the latched selection.
  always_comb begin
    w_price = PRICES[CREDIT_W-1:0];
    for (int i = 0; i < N_PROD; i++) begin
      if (r_sel == SEL_W'(i)) w_price = PRICES[i*CREDIT_W +: CREDIT_W];
    end
  end

  // Greedy change: largest coin not exceeding the remaining amount.
  always_comb begin
    w_chg_code = COIN_1;
    w_chg_val  = VAL_1;
    if (r_rem >= CREDIT_W'(5)) begin
      w_chg_code = COIN_5;
      w_chg_val  = VAL_5;
    end else if (r_rem >= CREDIT_W'(2)) begin
      w_chg_code = COIN_2;
      w_chg_val  = VAL_2;
    end
  end

  // Main controller: state, credit, change remainder, shared timer and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_credit    <= '0;
      r_rem       <= '0;
      r_sel       <= '0;
      r_timer     <= '0;
      product     <= '0;
      delivered   <= 1'b0;
      LED         <= '0;
      change_coin <= COIN_NONE;
      coin_reject <= 1'b0;
    end else begin
      change_coin <= COIN_NONE;
      coin_reject <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_coin_ev) coin_reject <= 1'b1;
          if (w_btn_ev) begin
            r_sel   <= w_btn_idx;
            LED     <= N_PROD'(1) << w_btn_idx;
            r_timer <= TMR_TO;
            r_state <= ST_SEL;
          end
        end
        ST_SEL: begin
          if (r_credit >= w_price) begin
            // Price covered: vend takes priority over cancel and timeout.
            r_rem     <= r_credit - w_price;
            r_credit  <= '0;
            product   <= LED;
            delivered <= 1'b1;
            r_timer   <= TMR_DISP;
            r_state   <= ST_VEND;
            if (w_coin_ev) coin_reject <= 1'b1;
          end else begin
            if (w_coin_ev && !w_fits) coin_reject <= 1'b1;
            if (w_reach) begin
              // Covering coin: credit it and vend next cycle, ignoring a coincident cancel.
              r_credit <= w_credit_nxt;
              r_timer  <= TMR_TO;
            end else if (w_cancel_ev || (r_timer == '0 && !w_coin_ev && !w_btn_ev)) begin
              // Refund includes a coin credited in the same cycle.
              r_rem    <= w_credit_nxt;
              r_credit <= '0;
              LED      <= '0;
              r_state  <= ST_CHANGE;
            end else begin
              r_credit <= w_credit_nxt;
              if (w_coin_ev || w_btn_ev) r_timer <= TMR_TO;
              else                       r_timer <= r_timer - TMR_W'(1);
            end
          end
        end
        ST_VEND: begin
          if (w_coin_ev) coin_reject <= 1'b1;
          if (r_timer == '0) begin
            product   <= '0;
            delivered <= 1'b0;
            LED       <= '0;
            r_state   <= (r_rem != '0) ? ST_CHANGE : ST_IDLE;
          end else begin
            r_timer <= r_timer - TMR_W'(1);
          end
        end
        ST_CHANGE: begin
          if (w_coin_ev) coin_reject <= 1'b1;
          if (r_rem == '0) begin
            r_state <= ST_IDLE;
          end else begin
            change_coin <= w_chg_code;
            r_rem       <= r_rem - CREDIT_W'(w_chg_val);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (r_state == ST_VEND) || (r_state == ST_CHANGE);

  assign w_tens  = 4'(r_credit / CREDIT_W'(10));
  assign w_units = 4'(r_credit % CREDIT_W'(10));

  vend_seg7 u_seg_units (
    .i_digit (w_units),
    .o_seg   (digit0)
  );

  vend_seg7 u_seg_tens (
    .i_digit (w_tens),
    .o_seg   (digit1)
  );

endmodule
